// File: rtl/fword_pkg.sv
// fword_pkg: wave codes, multiplier constants and FSM states shared by fword_ctrl.
package fword_pkg;
  localparam logic [1:0] WAVE_SIN = 2'b11;
  localparam logic [1:0] WAVE_SQU = 2'b10;
  localparam logic [1:0] WAVE_TRI = 2'b01;
  localparam logic [1:0] WAVE_SAW = 2'b00;
  localparam logic [22:0] K_SCALE = 23'd5_629_500;
  localparam int MUL_BITS = 20;
  localparam int ACC_W = 43;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  function automatic logic [1:0] next_wave(input logic [1:0] w);
    return w == WAVE_SIN ? WAVE_SQU : w == WAVE_SQU ? WAVE_TRI : w == WAVE_TRI ? WAVE_SAW : WAVE_SIN;
  endfunction
endpackage

// File: rtl/fword_ctrl_if.sv
// fword_ctrl_if: raw user keys in, DDS control word and status out.
interface fword_ctrl_if;
  logic        key_wave;
  logic        key_up;
  logic        key_down;
  logic [1:0]  wave_select;
  logic [31:0] freq_word;
  logic [19:0] freq_hz;
  logic        freq_valid;
  logic        busy;
  modport master (input key_wave, key_up, key_down, output wave_select, freq_word, freq_hz, freq_valid, busy);
  modport slave (output key_wave, key_up, key_down, input wave_select, freq_word, freq_hz, freq_valid, busy);
endinterface

// File: rtl/key_filter.sv
// key_filter: synchronizes and debounces one active-low key into a single press pulse.
module key_filter #(
  parameter logic [19:0] CNT_MAX = 20'd999_999
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n_i,
  output logic pulse_o
);
  logic [1:0]  sync_q;
  logic [19:0] cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], key_n_i};
      cnt_q  <= sync_q[1] ? '0 : cnt_q == CNT_MAX ? cnt_q : cnt_q + 20'd1;
    end
  end
  // counter parks at CNT_MAX while held, so this matches once per press
  assign pulse_o = cnt_q == CNT_MAX - 20'd1;
endmodule

// File: rtl/fword_ctrl.sv
// fword_ctrl: key-driven wave/frequency control producing the DDS phase-increment word
// via a 20-cycle LSB-first shift-add multiply.
module fword_ctrl
  import fword_pkg::*;
#(
  parameter logic [19:0] CNT_MAX = 20'd999_999,
  parameter int F_MIN  = 100,
  parameter int F_MAX  = 1_000_000,
  parameter int F_STEP = 100,
  parameter int F_INIT = 500
) (
  input logic         sys_clk,
  input logic         sys_rst,
  fword_ctrl_if.master bus
);
  localparam logic [ACC_W-1:0] INIT_PROD = ACC_W'(F_INIT) * ACC_W'(K_SCALE);
  localparam logic [31:0] INIT_WORD = {5'b0, INIT_PROD[ACC_W-1:16]};
  localparam logic [20:0] UP_LIM = 21'(F_MAX - F_STEP);
  localparam logic [20:0] DN_LIM = 21'(F_MIN + F_STEP);
  logic p_wave, p_up, p_down, go_up, go_dn;
  state_t           state_q;
  logic [1:0]       wave_q;
  logic [19:0]      freq_q;
  logic [31:0]      word_q;
  logic             valid_q, busy_q;
  logic [ACC_W-1:0] acc_q;
  logic [4:0]       bit_q;
  key_filter #(.CNT_MAX(CNT_MAX)) u_kw (.clk(sys_clk), .rst(sys_rst), .key_n_i(bus.key_wave), .pulse_o(p_wave));
  key_filter #(.CNT_MAX(CNT_MAX)) u_ku (.clk(sys_clk), .rst(sys_rst), .key_n_i(bus.key_up), .pulse_o(p_up));
  key_filter #(.CNT_MAX(CNT_MAX)) u_kd (.clk(sys_clk), .rst(sys_rst), .key_n_i(bus.key_down), .pulse_o(p_down));
  // simultaneous up and down cancel; out-of-range steps saturate silently
  assign go_up = p_up & ~p_down & ({1'b0, freq_q} <= UP_LIM);
  assign go_dn = p_down & ~p_up & ({1'b0, freq_q} >= DN_LIM);
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      wave_q  <= WAVE_SIN;
      freq_q  <= 20'(F_INIT);
      word_q  <= INIT_WORD;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      acc_q   <= '0;
      bit_q   <= '0;
    end else begin
      valid_q <= 1'b0;
      if (p_wave) wave_q <= next_wave(wave_q);
      case (state_q)
        IDLE: if (go_up || go_dn) begin
          freq_q  <= go_up ? freq_q + 20'(F_STEP) : freq_q - 20'(F_STEP);
          acc_q   <= '0;
          bit_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= CALC;
        end
        CALC: begin
          if (freq_q[bit_q]) acc_q <= acc_q + (ACC_W'(K_SCALE) << bit_q);
          bit_q <= bit_q + 5'd1;
          if (bit_q == 5'(MUL_BITS - 1)) state_q <= DONE;
        end
        default: begin
          word_q  <= {5'b0, acc_q[ACC_W-1:16]};
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end
  assign bus.wave_select = wave_q;
  assign bus.freq_word   = word_q;
  assign bus.freq_hz     = freq_q;
  assign bus.freq_valid  = valid_q;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_fword_ctrl.sv
// tb_fword_ctrl: randomized key presses on three fword_ctrl instances checked against an arithmetic model.
module tb_fword_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int vcnt [3];
  int bcnt = 0;
  int perr = 0;
  logic [31:0] prev0 = '0;
  int m_freq = 500;
  int m_wave = 3;
  fword_ctrl_if b0 ();
  fword_ctrl_if b1 ();
  fword_ctrl_if b2 ();
  fword_ctrl #(.CNT_MAX(20'd10)) dut0 (.sys_clk(clk), .sys_rst(rst), .bus(b0));
  fword_ctrl #(.CNT_MAX(20'd10), .F_INIT(999_900)) dut_hi (.sys_clk(clk), .sys_rst(rst), .bus(b1));
  fword_ctrl #(.CNT_MAX(20'd10), .F_INIT(100)) dut_lo (.sys_clk(clk), .sys_rst(rst), .bus(b2));
  always #5 clk = ~clk;
  function automatic longint word_of(input longint f);
    return (f * 64'd5629500) >> 16;
  endfunction
  always @(negedge clk) begin
    if (b0.freq_valid) vcnt[0]++;
    if (b1.freq_valid) vcnt[1]++;
    if (b2.freq_valid) vcnt[2]++;
    if (b0.busy) bcnt++;
    if (b0.busy && b0.freq_word !== prev0) perr++;
    prev0 = b0.freq_word;
  end
  task automatic set_key(input int d, input int k, input logic v);
    case (d)
      0: case (k) 0: b0.key_wave = v; 1: b0.key_up = v; default: b0.key_down = v; endcase
      1: case (k) 0: b1.key_wave = v; 1: b1.key_up = v; default: b1.key_down = v; endcase
      default: case (k) 0: b2.key_wave = v; 1: b2.key_up = v; default: b2.key_down = v; endcase
    endcase
  endtask
  task automatic press(input int d, input int k, input int n);
    set_key(d, k, 1'b0);
    repeat (n) @(negedge clk);
    set_key(d, k, 1'b1);
    repeat (45) @(negedge clk);
  endtask
  task automatic model_press(input int k);
    if (k == 0) m_wave = (m_wave + 3) % 4;
    else if (k == 1 && m_freq + 100 <= 1_000_000) m_freq += 100;
    else if (k == 2 && m_freq - 100 >= 100) m_freq -= 100;
  endtask
  task automatic test_reset;
    for (int d = 0; d < 3; d++) for (int k = 0; k < 3; k++) set_key(d, k, 1'b1);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    checks++; if (b0.wave_select !== 2'b11) begin errors++; $display("FAIL reset_wave: got %b want 11", b0.wave_select); end
    checks++; if (b0.freq_hz !== 20'd500) begin errors++; $display("FAIL reset_freq: got %0d want 500", b0.freq_hz); end
    checks++; if (b0.freq_word !== 32'(word_of(500))) begin errors++; $display("FAIL reset_word: got %0d want %0d", b0.freq_word, word_of(500)); end
    checks++; if (b0.freq_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", b0.freq_valid); end
    checks++; if (b0.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", b0.busy); end
    checks++; if (b1.freq_word !== 32'(word_of(999_900))) begin errors++; $display("FAIL reset_word_hi: got %0d want %0d", b1.freq_word, word_of(999_900)); end
    checks++; if (b2.freq_word !== 32'(word_of(100))) begin errors++; $display("FAIL reset_word_lo: got %0d want %0d", b2.freq_word, word_of(100)); end
    checks++; if (vcnt[0] + vcnt[1] + vcnt[2] !== 0) begin errors++; $display("FAIL reset_no_strobe: got %0d want 0", vcnt[0] + vcnt[1] + vcnt[2]); end
  endtask
  task automatic test_up;
    int n, v, bc, old;
    v = vcnt[0]; bc = bcnt; old = m_freq; n = 0;
    set_key(0, 1, 1'b0);
    while (!b0.busy && n < 100) begin @(negedge clk); n++; end
    checks++; if (n >= 100) begin errors++; $display("FAIL up_busy_rise: got timeout want busy"); end
    model_press(1);
    checks++; if (b0.freq_hz !== 20'(m_freq)) begin errors++; $display("FAIL up_freq_early: got %0d want %0d", b0.freq_hz, m_freq); end
    checks++; if (b0.freq_word !== 32'(word_of(old))) begin errors++; $display("FAIL up_word_held: got %0d want %0d", b0.freq_word, word_of(old)); end
    n = 0;
    while (!b0.freq_valid && n < 100) begin @(negedge clk); n++; end
    checks++; if (n !== 21) begin errors++; $display("FAIL up_latency: got %0d want 21", n); end
    set_key(0, 1, 1'b1);
    repeat (40) @(negedge clk);
    checks++; if (b0.freq_hz !== 20'(m_freq)) begin errors++; $display("FAIL up_freq: got %0d want %0d", b0.freq_hz, m_freq); end
    checks++; if (b0.freq_word !== 32'(word_of(m_freq))) begin errors++; $display("FAIL up_word: got %0d want %0d", b0.freq_word, word_of(m_freq)); end
    checks++; if (vcnt[0] - v !== 1) begin errors++; $display("FAIL up_strobes: got %0d want 1", vcnt[0] - v); end
    checks++; if (bcnt - bc !== 21) begin errors++; $display("FAIL up_busy_len: got %0d want 21", bcnt - bc); end
    checks++; if (perr !== 0) begin errors++; $display("FAIL up_partial_word: got %0d want 0", perr); end
  endtask
  task automatic test_down;
    int v;
    for (int i = 0; i < 2; i++) begin
      v = vcnt[0];
      press(0, 2, 20);
      model_press(2);
      checks++; if (b0.freq_hz !== 20'(m_freq)) begin errors++; $display("FAIL down_freq: got %0d want %0d", b0.freq_hz, m_freq); end
      checks++; if (b0.freq_word !== 32'(word_of(m_freq))) begin errors++; $display("FAIL down_word: got %0d want %0d", b0.freq_word, word_of(m_freq)); end
      checks++; if (vcnt[0] - v !== 1) begin errors++; $display("FAIL down_strobes: got %0d want 1", vcnt[0] - v); end
    end
  endtask
  task automatic test_min_sat;
    int v;
    v = vcnt[2];
    press(2, 2, 20);
    checks++; if (b2.freq_hz !== 20'd100) begin errors++; $display("FAIL min_freq: got %0d want 100", b2.freq_hz); end
    checks++; if (b2.freq_word !== 32'(word_of(100))) begin errors++; $display("FAIL min_word: got %0d want %0d", b2.freq_word, word_of(100)); end
    checks++; if (vcnt[2] !== v) begin errors++; $display("FAIL min_strobes: got %0d want %0d", vcnt[2], v); end
  endtask
  task automatic test_wave;
    for (int i = 0; i < 4; i++) begin
      press(0, 0, 20);
      model_press(0);
      checks++; if (b0.wave_select !== 2'(m_wave)) begin errors++; $display("FAIL wave_step: got %b want %b", b0.wave_select, 2'(m_wave)); end
      set_key(0, 0, 1'b0);
      repeat (5) @(negedge clk);
      set_key(0, 0, 1'b1);
      repeat (30) @(negedge clk);
      checks++; if (b0.wave_select !== 2'(m_wave)) begin errors++; $display("FAIL wave_glitch: got %b want %b", b0.wave_select, 2'(m_wave)); end
    end
  endtask
  task automatic test_max_sat;
    int v;
    v = vcnt[1];
    set_key(1, 1, 1'b0);
    repeat (5) @(negedge clk);
    set_key(1, 2, 1'b0);
    repeat (15) @(negedge clk);
    set_key(1, 1, 1'b1);
    repeat (5) @(negedge clk);
    set_key(1, 2, 1'b1);
    repeat (60) @(negedge clk);
    checks++; if (b1.freq_hz !== 20'd1_000_000) begin errors++; $display("FAIL max_freq: got %0d want 1000000", b1.freq_hz); end
    checks++; if (b1.freq_word !== 32'(word_of(1_000_000))) begin errors++; $display("FAIL max_word: got %0d want %0d", b1.freq_word, word_of(1_000_000)); end
    checks++; if (vcnt[1] - v !== 1) begin errors++; $display("FAIL max_drop_busy: got %0d want 1", vcnt[1] - v); end
    press(1, 1, 20);
    checks++; if (b1.freq_hz !== 20'd1_000_000) begin errors++; $display("FAIL max_sat_freq: got %0d want 1000000", b1.freq_hz); end
    checks++; if (vcnt[1] - v !== 1) begin errors++; $display("FAIL max_sat_strobe: got %0d want 1", vcnt[1] - v); end
    checks++; if (b1.busy !== 1'b0) begin errors++; $display("FAIL max_sat_busy: got %b want 0", b1.busy); end
  endtask
  task automatic test_random;
    int op, old, v;
    for (int i = 0; i < 12; i++) begin
      op = int'($urandom_range(0, 3));
      old = m_freq;
      v = vcnt[0];
      if (op == 3) begin
        set_key(0, 1, 1'b0);
        set_key(0, 2, 1'b0);
        repeat (20) @(negedge clk);
        set_key(0, 1, 1'b1);
        set_key(0, 2, 1'b1);
        repeat (45) @(negedge clk);
      end else begin
        press(0, op, int'($urandom_range(14, 30)));
        model_press(op);
      end
      checks++; if (b0.freq_hz !== 20'(m_freq)) begin errors++; $display("FAIL rand_freq op%0d: got %0d want %0d", op, b0.freq_hz, m_freq); end
      checks++; if (b0.freq_word !== 32'(word_of(m_freq))) begin errors++; $display("FAIL rand_word op%0d: got %0d want %0d", op, b0.freq_word, word_of(m_freq)); end
      checks++; if (b0.wave_select !== 2'(m_wave)) begin errors++; $display("FAIL rand_wave op%0d: got %b want %b", op, b0.wave_select, 2'(m_wave)); end
      checks++; if (vcnt[0] - v !== int'(m_freq != old)) begin errors++; $display("FAIL rand_strobe op%0d: got %0d want %0d", op, vcnt[0] - v, int'(m_freq != old)); end
    end
  endtask
  task automatic test_reset_mid_calc;
    int n, v;
    n = 0;
    set_key(0, 1, 1'b0);
    while (!b0.busy && n < 100) begin @(negedge clk); n++; end
    checks++; if (n >= 100) begin errors++; $display("FAIL midrst_busy_rise: got timeout want busy"); end
    set_key(0, 1, 1'b1);
    repeat (10) @(negedge clk);
    v = vcnt[0];
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_freq = 500;
    m_wave = 3;
    repeat (40) @(negedge clk);
    checks++; if (b0.freq_hz !== 20'd500) begin errors++; $display("FAIL midrst_freq: got %0d want 500", b0.freq_hz); end
    checks++; if (b0.freq_word !== 32'(word_of(500))) begin errors++; $display("FAIL midrst_word: got %0d want %0d", b0.freq_word, word_of(500)); end
    checks++; if (b0.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", b0.busy); end
    checks++; if (b0.wave_select !== 2'b11) begin errors++; $display("FAIL midrst_wave: got %b want 11", b0.wave_select); end
    checks++; if (vcnt[0] !== v) begin errors++; $display("FAIL midrst_strobe: got %0d want %0d", vcnt[0], v); end
    v = vcnt[0];
    press(0, 1, 20);
    model_press(1);
    checks++; if (b0.freq_word !== 32'(word_of(m_freq))) begin errors++; $display("FAIL midrst_resume: got %0d want %0d", b0.freq_word, word_of(m_freq)); end
    checks++; if (vcnt[0] - v !== 1) begin errors++; $display("FAIL midrst_resume_strobe: got %0d want 1", vcnt[0] - v); end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset;
    test_up;
    test_down;
    test_min_sat;
    test_wave;
    test_max_sat;
    test_random;
    test_reset_mid_calc;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
